// File: rtl/serial_bit_feeder_if.sv
// Word handshake between a parallel source and serial_bit_feeder.
// valid/ready: a word moves on every rising clk edge where din_valid and
// din_ready are both 1. Once din_valid is raised, the source holds it and din
// stable until that edge. din_ready does not depend on din_valid.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    // The source drives the word. The feeder answers with ready.
    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    // The feeder side.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts a parallel word over s_in (valid/ready) and
// shifts it out MSB-first on o_bit_out, one bit per i_bit_en strobe.
// o_bit_valid and o_frame_done pulse with each new bit and with the final bit
// of a frame, so downstream detectors can be aligned to bit positions.
//
// Optional feature, macro SERIAL_PARITY_EN:
//   defined   - an extra PAR state appends the even parity (XOR) of the
//               captured word as bit WIDTH, so the frame has WIDTH+1 bits.
//   undefined - the frame is exactly WIDTH bits, with no parity logic.
//
// Debug: o_dbg_state exposes the FSM state (0 IDLE, 1 SHIFT, 2 PAR) and
// o_dbg_cnt exposes the data-bit counter.
module serial_bit_feeder #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_bit_feeder_if.slave           s_in,
    input  logic                         i_bit_en,
    output logic                         o_bit_out,
    output logic                         o_bit_valid,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic [1:0]                   o_dbg_state,
    output logic [$clog2(WIDTH+1)-1:0]   o_dbg_cnt
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    // Registered state
    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bit_out;
    logic               r_bit_valid;
    logic               r_busy;
    logic               r_frame_done;
`ifdef SERIAL_PARITY_EN
    logic               r_par;
`endif

    // Next-state values
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_bit_out_nxt;
    logic               w_bit_valid_nxt;
    logic               w_busy_nxt;
    logic               w_frame_done_nxt;
    logic               w_accept;
    logic               w_last_bit;
`ifdef SERIAL_PARITY_EN
    logic               w_par_nxt;
`endif

    // Ready is purely a state decode, so it reads 1 throughout reset.
    assign s_in.din_ready = (r_state == ST_IDLE);
    assign w_accept       = s_in.din_valid && (r_state == ST_IDLE);
    assign w_last_bit     = (r_cnt == LAST_CNT);

    assign o_bit_out      = r_bit_out;
    assign o_bit_valid    = r_bit_valid;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_frame_done;
    assign o_dbg_state    = r_state;
    assign o_dbg_cnt      = r_cnt;

    // Next-state and output decode; every register holds unless a state says otherwise.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_bit_out_nxt    = r_bit_out;
        w_bit_valid_nxt  = 1'b0;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
`ifdef SERIAL_PARITY_EN
        w_par_nxt        = r_par;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // The capture cycle ignores the strobe. If the next word
                    // arrives before any strobe, the line keeps the last bit of
                    // the previous frame and never returns to the idle level.
                    w_shift_nxt = s_in.din;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                    w_busy_nxt  = 1'b1;
`ifdef SERIAL_PARITY_EN
                    w_par_nxt   = ^s_in.din;
`endif
                end else if (i_bit_en) begin
                    w_bit_out_nxt = IDLE_LEVEL;
                end
            end

            ST_SHIFT: begin
                if (i_bit_en) begin
                    w_bit_out_nxt   = r_shift[WIDTH-1];
                    w_shift_nxt     = {r_shift[WIDTH-2:0], 1'b0};
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_bit_valid_nxt = 1'b1;
                    if (w_last_bit) begin
`ifdef SERIAL_PARITY_EN
                        w_state_nxt      = ST_PAR;
`else
                        w_state_nxt      = ST_IDLE;
                        w_busy_nxt       = 1'b0;
                        w_frame_done_nxt = 1'b1;
`endif
                    end
                end
            end

`ifdef SERIAL_PARITY_EN
            ST_PAR: begin
                if (i_bit_en) begin
                    w_bit_out_nxt    = r_par;
                    w_bit_valid_nxt  = 1'b1;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                    w_busy_nxt       = 1'b0;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any frame without a frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_bit_out    <= IDLE_LEVEL;
            r_bit_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_out    <= w_bit_out_nxt;
            r_bit_valid  <= w_bit_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
`ifdef SERIAL_PARITY_EN
            r_par        <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder (WIDTH=8, IDLE_LEVEL=1).
// Inputs change 1ns after the rising edge, and outputs are sampled at that same point.
module tb_serial_bit_feeder;
    localparam int W = 8;
`ifdef SERIAL_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       bit_out, bit_valid, busy, frame_done;
    logic [1:0] dbg_state;
    logic [3:0] dbg_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic obs_bit   [0:79];
    logic obs_valid [0:79];
    logic obs_done  [0:79];
    logic obs_busy  [0:79];
    logic obs_ready [0:79];

    serial_bit_feeder_if #(.WIDTH(W)) u_if ();

    serial_bit_feeder #(.WIDTH(W), .IDLE_LEVEL(1'b1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .s_in         (u_if),
        .i_bit_en     (bit_en),
        .o_bit_out    (bit_out),
        .o_bit_valid  (bit_valid),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_dbg_state  (dbg_state),
        .o_dbg_cnt    (dbg_cnt)
    );

    always #5 clk = ~clk;

    // Driver: offer a word and hold it until it is taken (bounded wait).
    task automatic send_word(input logic [W-1:0] w);
        int waited;
        waited = 0;
        u_if.din       = w;
        u_if.din_valid = 1'b1;
        while (!u_if.din_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!u_if.din_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout din_ready got=%b exp=1", u_if.din_ready);
        end
        @(posedge clk); #1;
        u_if.din_valid = 1'b0;
    endtask

    // Driver: strobe bit_en once every 'period' clocks and record outputs after each edge.
    task automatic capture(input int period, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bit_en = ((c % period) == (period - 1));
            @(posedge clk); #1;
            obs_bit[c]   = bit_out;
            obs_valid[c] = bit_valid;
            obs_done[c]  = frame_done;
            obs_busy[c]  = busy;
            obs_ready[c] = u_if.din_ready;
        end
        bit_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.din = 8'hA5;
        u_if.din_valid = 1'b1;
        bit_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (bit_out !== 1'b1)       begin n_err++; $display("FAIL rst_bit_out got=%b exp=1", bit_out); end
        n_cmp++; if (bit_valid !== 1'b0)     begin n_err++; $display("FAIL rst_bit_valid got=%b exp=0", bit_valid); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (frame_done !== 1'b0)    begin n_err++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        n_cmp++; if (u_if.din_ready !== 1'b1) begin n_err++; $display("FAIL rst_din_ready got=%b exp=1", u_if.din_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1)          begin n_err++; $display("FAIL first_accept_busy got=%b exp=1", busy); end
        n_cmp++; if (u_if.din_ready !== 1'b0) begin n_err++; $display("FAIL first_accept_ready got=%b exp=0", u_if.din_ready); end
        u_if.din_valid = 1'b0;
        capture(1, FB + 2);
    endtask

    task automatic test_basic_frame();
        logic [W-1:0] exp_w;
        logic         exp_b;
        exp_w = 8'hA5;  // bits 1,0,1,0,0,1,0,1
        send_word(exp_w);
        capture(1, FB + 2);
        for (int c = 0; c < FB; c++) begin
            exp_b = (c < W) ? exp_w[W-1-c] : ^exp_w;
            n_cmp++; if (obs_bit[c] !== exp_b)   begin n_err++; $display("FAIL basic_bit c=%0d got=%b exp=%b", c, obs_bit[c], exp_b); end
            n_cmp++; if (obs_valid[c] !== 1'b1)  begin n_err++; $display("FAIL basic_valid c=%0d got=%b exp=1", c, obs_valid[c]); end
            n_cmp++; if (obs_done[c] !== (c == FB-1)) begin n_err++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, obs_done[c], (c == FB-1)); end
            n_cmp++; if (obs_busy[c] !== (c != FB-1)) begin n_err++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, obs_busy[c], (c != FB-1)); end
        end
        n_cmp++; if (obs_bit[FB] !== 1'b1)   begin n_err++; $display("FAIL basic_idle_level got=%b exp=1", obs_bit[FB]); end
        n_cmp++; if (obs_valid[FB] !== 1'b0) begin n_err++; $display("FAIL basic_valid_after got=%b exp=0", obs_valid[FB]); end
        n_cmp++; if (obs_done[FB] !== 1'b0)  begin n_err++; $display("FAIL basic_done_after got=%b exp=0", obs_done[FB]); end
        n_cmp++; if (obs_ready[FB] !== 1'b1) begin n_err++; $display("FAIL basic_ready_after got=%b exp=1", obs_ready[FB]); end
        n_cmp++; if (obs_valid[FB+1] !== 1'b0) begin n_err++; $display("FAIL basic_valid_idle got=%b exp=0", obs_valid[FB+1]); end
    endtask

    task automatic test_slow_strobe();
        logic [W-1:0] exp_w;
        logic         exp_b;
        logic         exp_v;
        int           pulses;
        int           k;
        exp_w = 8'h3C;  // bits 0,0,1,1,1,1,0,0
        pulses = 0;
        send_word(exp_w);
        capture(4, 4*FB + 2);
        for (int c = 0; c < 4*FB + 2; c++) begin
            exp_v = ((c % 4) == 3) && ((c / 4) < FB);
            if (obs_valid[c]) pulses++;
            n_cmp++; if (obs_valid[c] !== exp_v) begin n_err++; $display("FAIL slow_valid c=%0d got=%b exp=%b", c, obs_valid[c], exp_v); end
            if (c >= 3 && ((c - 3) / 4) < FB) begin
                k = (c - 3) / 4;
                exp_b = (k < W) ? exp_w[W-1-k] : ^exp_w;
                n_cmp++; if (obs_bit[c] !== exp_b) begin n_err++; $display("FAIL slow_bit c=%0d got=%b exp=%b", c, obs_bit[c], exp_b); end
            end
            n_cmp++; if (obs_ready[c] !== (c >= 4*FB - 1)) begin n_err++; $display("FAIL slow_ready c=%0d got=%b exp=%b", c, obs_ready[c], (c >= 4*FB - 1)); end
            n_cmp++; if (obs_done[c] !== (c == 4*FB - 1)) begin n_err++; $display("FAIL slow_done c=%0d got=%b exp=%b", c, obs_done[c], (c == 4*FB - 1)); end
        end
        n_cmp++; if (pulses !== FB) begin n_err++; $display("FAIL slow_pulse_count got=%0d exp=%0d", pulses, FB); end
    endtask

    // A 0101 non-overlapping detector consumes the line on each bit_valid.
    task automatic test_detector_chain();
        logic [3:0] hist;
        int         seen, ndet, bidx;
        int         det_at [0:1];
        hist = 4'b0; seen = 0; ndet = 0; bidx = 0;
        det_at[0] = -1; det_at[1] = -1;
        send_word(8'h55);
        capture(1, FB + 2);
        for (int c = 0; c < FB + 2; c++) begin
            if (obs_valid[c] && bidx < W) begin
                hist = {hist[2:0], obs_bit[c]};
                seen++;
                if (seen >= 4 && hist == 4'b0101) begin
                    if (ndet < 2) det_at[ndet] = bidx;
                    ndet++;
                    seen = 0;
                end
                bidx++;
            end
        end
        n_cmp++; if (ndet !== 2)      begin n_err++; $display("FAIL det_count got=%0d exp=2", ndet); end
        n_cmp++; if (det_at[0] !== 3) begin n_err++; $display("FAIL det_first got=%0d exp=3", det_at[0]); end
        n_cmp++; if (det_at[1] !== 7) begin n_err++; $display("FAIL det_second got=%0d exp=7", det_at[1]); end
    endtask

    task automatic test_back_to_back();
        logic         exp_q [$];
        logic [W-1:0] words [0:1];
        logic         acc, exp_b;
        int           idx, n_done, n_valid;
        int           acc_cyc [0:1];
        int           done_cyc [0:1];
        words[0] = 8'hFF; words[1] = 8'h00;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < W; k++) exp_q.push_back(words[j][W-1-k]);
`ifdef SERIAL_PARITY_EN
            exp_q.push_back(^words[j]);
`endif
        end
        idx = 0; n_done = 0; n_valid = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1; done_cyc[0] = -1; done_cyc[1] = -1;
        u_if.din = words[0];
        u_if.din_valid = 1'b1;
        bit_en = 1'b1;
        for (int c = 0; c < 2*FB + 6; c++) begin
            acc = u_if.din_valid && u_if.din_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (idx < 2) acc_cyc[idx] = c;
                idx++;
                if (idx < 2) u_if.din = words[idx];
                else u_if.din_valid = 1'b0;
            end
            if (frame_done) begin
                if (n_done < 2) done_cyc[n_done] = c;
                n_done++;
            end
            if (bit_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b2b_extra_bit c=%0d got=%b exp=none", c, bit_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    n_cmp++; if (bit_out !== exp_b) begin n_err++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, bit_out, exp_b); end
                end
            end
        end
        bit_en = 1'b0;
        u_if.din_valid = 1'b0;
        n_cmp++; if (exp_q.size() !== 0)   begin n_err++; $display("FAIL b2b_missing_bits got=%0d exp=0", exp_q.size()); end
        n_cmp++; if (idx !== 2)            begin n_err++; $display("FAIL b2b_accepts got=%0d exp=2", idx); end
        n_cmp++; if (acc_cyc[0] !== 0)     begin n_err++; $display("FAIL b2b_accept0 got=%0d exp=0", acc_cyc[0]); end
        n_cmp++; if (acc_cyc[1] !== FB+1)  begin n_err++; $display("FAIL b2b_accept1 got=%0d exp=%0d", acc_cyc[1], FB+1); end
        n_cmp++; if (n_done !== 2)         begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        n_cmp++; if (done_cyc[0] !== FB)   begin n_err++; $display("FAIL b2b_done0 got=%0d exp=%0d", done_cyc[0], FB); end
        n_cmp++; if (done_cyc[1] !== 2*FB+1) begin n_err++; $display("FAIL b2b_done1 got=%0d exp=%0d", done_cyc[1], 2*FB+1); end
        n_cmp++; if (n_valid !== 2*FB)     begin n_err++; $display("FAIL b2b_valid_count got=%0d exp=%0d", n_valid, 2*FB); end
    endtask

    task automatic test_reset_mid_frame();
        int n_done, n_busy;
        n_done = 0; n_busy = 0;
        send_word(8'hF0);
        capture(1, 3);
        rst = 1'b1;
        #1;
        n_cmp++; if (bit_out !== 1'b1)        begin n_err++; $display("FAIL midrst_bit_out got=%b exp=1", bit_out); end
        n_cmp++; if (bit_valid !== 1'b0)      begin n_err++; $display("FAIL midrst_bit_valid got=%b exp=0", bit_valid); end
        n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (frame_done !== 1'b0)     begin n_err++; $display("FAIL midrst_frame_done got=%b exp=0", frame_done); end
        n_cmp++; if (u_if.din_ready !== 1'b1) begin n_err++; $display("FAIL midrst_din_ready got=%b exp=1", u_if.din_ready); end
        bit_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (frame_done) n_done++;
            if (busy) n_busy++;
        end
        bit_en = 1'b0;
        n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", n_done); end
        n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL midrst_stays_idle got=%0d exp=0", n_busy); end
    endtask

`ifdef SERIAL_PARITY_EN
    task automatic test_parity();
        logic [8:0] exp_a;
        logic [8:0] exp_b;
        exp_a = 9'b000001111;  // 8'h07 followed by parity 1
        exp_b = 9'b000000110;  // 8'h03 followed by parity 0
        send_word(8'h07);
        capture(1, FB + 2);
        for (int c = 0; c < 9; c++) begin
            n_cmp++; if (obs_bit[c] !== exp_a[8-c]) begin n_err++; $display("FAIL par07_bit c=%0d got=%b exp=%b", c, obs_bit[c], exp_a[8-c]); end
            n_cmp++; if (obs_done[c] !== (c == 8))  begin n_err++; $display("FAIL par07_done c=%0d got=%b exp=%b", c, obs_done[c], (c == 8)); end
        end
        send_word(8'h03);
        capture(1, FB + 2);
        for (int c = 0; c < 9; c++) begin
            n_cmp++; if (obs_bit[c] !== exp_b[8-c]) begin n_err++; $display("FAIL par03_bit c=%0d got=%b exp=%b", c, obs_bit[c], exp_b[8-c]); end
        end
    endtask
`endif

    initial begin
        u_if.din = '0;
        u_if.din_valid = 1'b0;
        test_reset();
        test_basic_frame();
        test_slow_strobe();
        test_detector_chain();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SERIAL_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Upstream stage for the serial sequence detectors. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per bit_en strobe, on a single-bit line (bit_out). That line drives a detector's serial data input directly. The block also emits per-bit and per-frame status so benches and downstream logic can align detector outputs to bit positions.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- IDLE_LEVEL, 1'b1, level driven on bit_out while no frame is active.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word; combinational, equals (state==IDLE).
- bit_en  input  1  bit-rate strobe; one bit advances per clock in which bit_en=1.
- bit_out  output  1  registered serial data; feeds the detector's serial input.
- bit_valid  output  1  registered; one-clock pulse coincident with each new bit on bit_out.
- busy  output  1  registered; 1 while state is SHIFT or PAR.
- frame_done  output  1  registered; one-clock pulse coincident with the final bit of a frame.

Behaviour:
- Reset (async): state=IDLE, bit_out=IDLE_LEVEL, bit_valid=0, busy=0, frame_done=0, shift register=0, bit counter=0. din_ready reads 1 while in IDLE, including during reset.
- States: IDLE, SHIFT, and PAR (PAR exists only with PARITY_EN).
- IDLE:
  - On din_valid & din_ready: shift_reg<=din, cnt<=0, state<=SHIFT, busy<=1. The word is captured in that cycle and din may then change.
  - If bit_en=1 in IDLE, bit_out<=IDLE_LEVEL. Otherwise bit_out holds its value.
  - bit_en in the acceptance cycle is ignored.
- SHIFT, on each bit_en:
  - bit_out<=shift_reg[WIDTH-1], shift_reg<=shift_reg<<1, cnt<=cnt+1, bit_valid<=1.
  - Without bit_en: bit_out holds, bit_valid<=0.
- Last data bit (cnt==WIDTH-1 and bit_en):
  - Without PARITY_EN: frame_done<=1, state<=IDLE, busy<=0.
  - With PARITY_EN: state<=PAR, and frame_done is not pulsed.
- Latency: the k-th data bit (k=0 is the MSB) appears on bit_out one clock after the (k+1)-th bit_en that follows the acceptance cycle.
- Between strobes, bit_out holds the current bit for every clock. A detector sampling every clock therefore sees each bit repeated for the full strobe period.
- din_valid while busy: no acceptance and no loss. The source must hold din_valid until din_ready=1.
- Back-to-back frames: a word waiting at frame end is accepted in the first IDLE cycle, which gives a minimum one-clock gap. bit_out keeps the last frame bit until a bit_en occurs; if the new word is accepted before any bit_en, bit_out never returns to IDLE_LEVEL between the frames.
- cnt width is clog2(WIDTH+1). cnt never exceeds WIDTH-1 in SHIFT.
- Reset mid-frame: the frame is abandoned, all outputs return to reset values, and no frame_done is issued.
- bit_valid and frame_done are 0 in every cycle without bit_en.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined: the PAR state is present.
  - After the last data bit, the next bit_en drives bit_out<=even parity of the captured word (XOR of all WIDTH bits), bit_valid<=1, frame_done<=1, state<=IDLE, busy<=0.
  - The frame is WIDTH+1 bits long. The block keeps a copy of the captured word, or a running XOR, for parity.
- Undefined: there is no PAR state and no parity logic. The frame is exactly WIDTH bits, and frame_done pulses with the last data bit.

Test Plan:
- Reset: assert rst for 2 clocks with din_valid=1 -> bit_out=1, bit_valid=0, busy=0, frame_done=0, din_ready=1 during reset. The first accept occurs in the first clock after rst falls.
- Basic frame: din=8'hA5 with bit_en=1 every clock -> bit_out sequence 1,0,1,0,0,1,0,1 on consecutive clocks, bit_valid high for 8 clocks, frame_done only on the 8th bit, busy falls in the same cycle.
- Slow strobe: din=8'h3C with bit_en every 4th clock -> each bit held for 4 clocks. bit_valid pulses one clock per bit (8 pulses total). din_ready stays 0 for the whole frame.
- Detector chain: din=8'h55 fed into the 0101 non-overlapping detector with bit_en=1 every clock -> detector pulses twice, aligned to data bits 3 and 7.
- Back-to-back and reset: din_valid held with 8'hFF then 8'h00 -> second word accepted one clock after the first frame ends, with no words lost. Separately, assert rst after 3 bits of 8'hF0 -> outputs return to reset values immediately and no frame_done is issued.
- Parity (SERIAL_PARITY_EN defined): din=8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1. frame_done is on the 9th bit only. din=8'h03 gives parity bit 0.
